fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, PC step, default reset vector, FSM states.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
   localparam logic [31:0] PC_INC               = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic {
      FETCH_BOOT = 1'b0,
      FETCH_RUN  = 1'b1
   } fetchState_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on ~en, inserts a bubble on clr, otherwise loads a valid instruction.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [INSTR_WIDTH-1:0] instrIn,
   input  logic [ADDR_WIDTH-1:0]  pcPlus4In,
   output logic [INSTR_WIDTH-1:0] instrOut,
   output logic [ADDR_WIDTH-1:0]  pcPlus4Out,
   output logic                   validOut
);

   // Stall (en low) wins over clear so a held decode slot is never silently dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         instrOut   <= INSTR_WIDTH'(NOP_INSTR);
         pcPlus4Out <= '0;
         validOut   <= 1'b0;
      end else if (en) begin
         if (clr) begin
            instrOut   <= INSTR_WIDTH'(NOP_INSTR);
            pcPlus4Out <= '0;
            validOut   <= 1'b0;
         end else begin
            instrOut   <= instrIn;
            pcPlus4Out <= pcPlus4In;
            validOut   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, boot/run FSM, instruction-memory handshake and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          BOOT_CYCLES  = 4,
   parameter int          ADDR_WIDTH   = 32,
   parameter int          INSTR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   StallF,
   input  logic                   StallD,
   input  logic                   PCSrcD,
   input  logic                   JumpD,
   input  logic [ADDR_WIDTH-1:0]  PCBranchD,
   input  logic [ADDR_WIDTH-1:0]  PCJumpD,
   input  logic [INSTR_WIDTH-1:0] imem_rd_data,
   input  logic                   imem_ready,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  PCF,
   output logic [INSTR_WIDTH-1:0] InstrD,
   output logic [ADDR_WIDTH-1:0]  PCPlus4D,
   output logic                   ValidD,
   output logic [31:0]            fetch_count
);

   localparam int                CNT_W       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  BOOT_LAST   = (BOOT_CYCLES > 0) ? CNT_W'(BOOT_CYCLES - 1) : '0;
   // With no boot delay the fetcher comes out of reset already running.
   localparam fetchState_t       RESET_STATE = (BOOT_CYCLES == 0) ? FETCH_RUN : FETCH_BOOT;

   fetchState_t           state, stateNext;
   logic [CNT_W-1:0]      bootCnt, bootCntNext;
   logic                  running;
   logic                  redirect;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] pcPlus4F;

   // Redirects only mean something once fetching has started; in BOOT decode holds bubbles.
   assign running  = (state == FETCH_RUN);
   assign redirect = running & (PCSrcD | JumpD);
   assign accept   = running & imem_ready & ~StallF;
   assign target   = JumpD ? {PCJumpD[ADDR_WIDTH-1:2], 2'b00}
                           : {PCBranchD[ADDR_WIDTH-1:2], 2'b00};
   assign pcPlus4F = PCF + ADDR_WIDTH'(PC_INC);

   assign imem_addr = PCF;

   // FSM state and boot counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RESET_STATE;
         bootCnt <= '0;
      end else begin
         state   <= stateNext;
         bootCnt <= bootCntNext;
      end
   end

   // Next state: count boot cycles, then stay in RUN until reset.
   always_comb begin
      stateNext   = state;
      bootCntNext = bootCnt;
      imem_req    = 1'b0;
      case (state)
         FETCH_BOOT: begin
            bootCntNext = bootCnt + CNT_W'(1);
            if (bootCnt == BOOT_LAST) stateNext = FETCH_RUN;
         end
         FETCH_RUN: begin
            imem_req = 1'b1;
         end
         default: stateNext = RESET_STATE;
      endcase
   end

   // PC update: stall beats redirect (hazard unit replays it), a redirect abandons the
   // in-flight fetch, otherwise advance only when memory delivers.
   always_ff @(posedge clk) begin
      if (rst)                PCF <= ADDR_WIDTH'(RESET_VECTOR);
      else if (StallF)        PCF <= PCF;
      else if (redirect)      PCF <= target;
      else if (accept)        PCF <= pcPlus4F;
   end

   // Count instructions that actually reach decode.
   always_ff @(posedge clk) begin
      if (rst)                                     fetch_count <= '0;
      else if (accept & ~redirect & ~StallD)       fetch_count <= fetch_count + 32'd1;
   end

   if_id_reg #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) uIfId (
      .clk        (clk),
      .rst        (rst),
      .en         (~StallD),
      .clr        (redirect | ~accept),
      .instrIn    (imem_rd_data),
      .pcPlus4In  (pcPlus4F),
      .instrOut   (InstrD),
      .pcPlus4Out (PCPlus4D),
      .validOut   (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, StallD, PCSrcD, JumpD;
   logic [31:0] PCBranchD, PCJumpD;
   logic [31:0] imem_rd_data;
   logic        imem_ready;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] PCF, InstrD, PCPlus4D;
   logic        ValidD;
   logic [31:0] fetch_count;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_rd_data = memWord(imem_addr);

   fetch_stage #(
      .RESET_VECTOR (32'h0),
      .BOOT_CYCLES  (4),
      .ADDR_WIDTH   (32),
      .INSTR_WIDTH  (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .StallF       (StallF),
      .StallD       (StallD),
      .PCSrcD       (PCSrcD),
      .JumpD        (JumpD),
      .PCBranchD    (PCBranchD),
      .PCJumpD      (PCJumpD),
      .imem_rd_data (imem_rd_data),
      .imem_ready   (imem_ready),
      .imem_addr    (imem_addr),
      .imem_req     (imem_req),
      .PCF          (PCF),
      .InstrD       (InstrD),
      .PCPlus4D     (PCPlus4D),
      .ValidD       (ValidD),
      .fetch_count  (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic chkDec(input string tag, input logic [31:0] instr,
                         input logic [31:0] pcp4, input logic vld);
      chk({tag, ".InstrD"},   InstrD,   instr);
      chk({tag, ".PCPlus4D"}, PCPlus4D, pcp4);
      chk({tag, ".ValidD"},   {31'b0, ValidD}, {31'b0, vld});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
      PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b1;
      step(); step();

      // Reset state
      chk("rst.PCF", PCF, 32'h0);
      chkDec("rst", 32'h0, 32'h0, 1'b0);
      chk("rst.count", fetch_count, 32'h0);
      chk("rst.req", {31'b0, imem_req}, 32'h0);
      rst = 1'b0;

      // Boot: request stays low for the remaining three boot cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("boot%0d.req", i), {31'b0, imem_req}, 32'h0);
         chk($sformatf("boot%0d.PCF", i), PCF, 32'h0);
      end
      step();
      chk("run.req", {31'b0, imem_req}, 32'h1);
      chk("run.PCF", PCF, 32'h0);
      chk("run.valid", {31'b0, ValidD}, 32'h0);
      step();
      chk("f1.PCF", PCF, 32'h4);
      chkDec("f1", memWord(32'h0), 32'h4, 1'b1);
      chk("f1.count", fetch_count, 32'd1);
      step();
      chk("f2.PCF", PCF, 32'h8);
      chkDec("f2", memWord(32'h4), 32'h8, 1'b1);
      step(); step();
      chk("f4.PCF", PCF, 32'h10);
      chk("f4.count", fetch_count, 32'd4);

      // Wait states at 0x10
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("ws%0d.PCF", i), PCF, 32'h10);
         chk($sformatf("ws%0d.valid", i), {31'b0, ValidD}, 32'h0);
         chk($sformatf("ws%0d.count", i), fetch_count, 32'd4);
      end
      imem_ready = 1'b1;
      step();
      chk("wsDone.PCF", PCF, 32'h14);
      chkDec("wsDone", memWord(32'h10), 32'h14, 1'b1);
      chk("wsDone.count", fetch_count, 32'd5);
      step(); step(); step();
      chk("preStall.PCF", PCF, 32'h20);
      chkDec("preStall", memWord(32'h1C), 32'h20, 1'b1);
      chk("preStall.count", fetch_count, 32'd8);

      // Stall both stages for two cycles
      StallF = 1'b1; StallD = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("st%0d.PCF", i), PCF, 32'h20);
         chk($sformatf("st%0d.addr", i), imem_addr, 32'h20);
         chk($sformatf("st%0d.req", i), {31'b0, imem_req}, 32'h1);
         chkDec($sformatf("st%0d", i), memWord(32'h1C), 32'h20, 1'b1);
         chk($sformatf("st%0d.count", i), fetch_count, 32'd8);
      end
      StallF = 1'b0; StallD = 1'b0;
      step();
      chk("stRel.PCF", PCF, 32'h24);
      chkDec("stRel", memWord(32'h20), 32'h24, 1'b1);
      chk("stRel.count", fetch_count, 32'd9);

      // Taken branch with misaligned target
      PCSrcD = 1'b1; PCBranchD = 32'h103;
      step();
      PCSrcD = 1'b0;
      chk("br.PCF", PCF, 32'h100);
      chkDec("br", 32'h0, 32'h0, 1'b0);
      chk("br.count", fetch_count, 32'd9);
      step();
      chk("brNext.PCF", PCF, 32'h104);
      chkDec("brNext", memWord(32'h100), 32'h104, 1'b1);
      chk("brNext.count", fetch_count, 32'd10);

      // Jump wins over branch
      JumpD = 1'b1; PCSrcD = 1'b1; PCJumpD = 32'h200; PCBranchD = 32'h300;
      step();
      JumpD = 1'b0; PCSrcD = 1'b0;
      chk("jmp.PCF", PCF, 32'h200);
      chk("jmp.valid", {31'b0, ValidD}, 32'h0);

      // Wrap from the top of the address space
      JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFF;
      step();
      JumpD = 1'b0;
      chk("wrapJ.PCF", PCF, 32'hFFFF_FFFC);
      chk("wrapJ.count", fetch_count, 32'd10);
      step();
      chk("wrap.PCF", PCF, 32'h0);
      chkDec("wrap", memWord(32'hFFFF_FFFC), 32'h0, 1'b1);
      chk("wrap.count", fetch_count, 32'd11);
      step();
      chk("post.PCF", PCF, 32'h4);
      chk("post.count", fetch_count, 32'd12);

      // Reset during a wait state with decode stalled
      imem_ready = 1'b0; StallD = 1'b1; rst = 1'b1;
      step();
      chk("mrst.PCF", PCF, 32'h0);
      chkDec("mrst", 32'h0, 32'h0, 1'b0);
      chk("mrst.count", fetch_count, 32'h0);
      chk("mrst.req", {31'b0, imem_req}, 32'h0);
      rst = 1'b0; StallD = 1'b0; imem_ready = 1'b1;

      // Redirect during boot is ignored
      JumpD = 1'b1; PCJumpD = 32'h400;
      step();
      JumpD = 1'b0;
      chk("bootJ.PCF", PCF, 32'h0);
      chk("bootJ.valid", {31'b0, ValidD}, 32'h0);
      chk("bootJ.req", {31'b0, imem_req}, 32'h0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
